// File: rtl/stack_pkg.sv
// Shared defaults and state encoding for the stack exerciser.
package stack_pkg;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned COUNT_W    = 6;
  localparam int unsigned MISMATCH_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    PUSH_GAP,
    POP,
    POP_GAP,
    FINISH
  } state_t;
endpackage

// File: rtl/stack_gap_timer.sv
// Down-counter producing the idle gap after each push/pop strobe.
// Loading starts a gap of GAP cycles; expire is high in the last of them.
module stack_gap_timer
  import stack_pkg::*;
#(
  parameter int unsigned GAP = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam int unsigned CW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  logic [CW-1:0] cnt;

  // Load the gap length, then count down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(GAP);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = (cnt == CW'(1));

endmodule

// File: rtl/stack_exerciser.sv
// Stack exerciser: pushes N incrementing values, pops them back and
// checks LIFO order, reporting mismatches and error_in activity.
module stack_exerciser
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned GAP    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COUNT_W-1:0]    count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  push,
  output logic                  pop,
  output logic [DATA_W-1:0]     data_out,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  error_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [MISMATCH_W-1:0] mismatch_cnt
);

  state_t                state, state_nx;
  logic [COUNT_W-1:0]    n_q, idx_q, idx_inc, n_in;
  logic [DATA_W-1:0]     seed_q, exp_pop;
  logic [MISMATCH_W-1:0] mm_q, mm_nx;
  logic                  err_q, err_nx, pass_q;
  logic                  start_acc, gap_load, gap_expire, pop_phase_entry;

  assign start_acc       = (state == IDLE) && start;
  assign n_in            = (32'(count) > DEPTH) ? COUNT_W'(DEPTH) : count;
  assign idx_inc         = idx_q + COUNT_W'(1);
  assign exp_pop         = seed_q + DATA_W'(n_q - idx_inc);
  assign pop_phase_entry = (state_nx == POP) && ((state == PUSH) || (state == PUSH_GAP));
  assign busy            = (state != IDLE);
  assign pass            = pass_q;
  assign mismatch_cnt    = mm_q;

  stack_gap_timer #(.GAP(GAP)) u_gap (
    .clk    (clk),
    .reset  (reset),
    .load   (gap_load),
    .expire (gap_expire)
  );

  // Next-state and strobe decode; gap states are bypassed when GAP is zero.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    pop      = 1'b0;
    data_out = '0;
    done     = 1'b0;
    gap_load = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (n_in == '0) ? FINISH : PUSH;
      end
      PUSH: begin
        push     = 1'b1;
        data_out = seed_q + DATA_W'(idx_q);
        if (GAP == 0) begin
          state_nx = (idx_inc == n_q) ? POP : PUSH;
        end else begin
          gap_load = 1'b1;
          state_nx = PUSH_GAP;
        end
      end
      PUSH_GAP: begin
        if (gap_expire) state_nx = (idx_q == n_q) ? POP : PUSH;
      end
      POP: begin
        pop = 1'b1;
        if (GAP == 0) begin
          state_nx = (idx_inc == n_q) ? FINISH : POP;
        end else begin
          gap_load = 1'b1;
          state_nx = POP_GAP;
        end
      end
      POP_GAP: begin
        if (gap_expire) state_nx = (idx_q == n_q) ? FINISH : POP;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Run bookkeeping for the cycle being closed: mismatch count and error history.
  always_comb begin
    mm_nx  = mm_q;
    err_nx = err_q | (busy & error_in);
    if (pop && (data_in != exp_pop) && (mm_q != '1)) mm_nx = mm_q + MISMATCH_W'(1);
    if (start_acc) begin
      mm_nx  = '0;
      err_nx = 1'b0;
    end
  end

  // State, run context and verdict registers.
  // The verdict is loaded on entry to FINISH from the next-cycle history so
  // that a mismatch on the final pop (GAP=0) is already included when done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      n_q    <= '0;
      idx_q  <= '0;
      seed_q <= '0;
      mm_q   <= '0;
      err_q  <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state <= state_nx;
      mm_q  <= mm_nx;
      err_q <= err_nx;
      if (start_acc) begin
        n_q    <= n_in;
        seed_q <= seed;
        pass_q <= 1'b0;
      end
      if (start_acc || pop_phase_entry) begin
        idx_q <= '0;
      end else if (push || pop) begin
        idx_q <= idx_inc;
      end
      if ((state_nx == FINISH) && (state != FINISH)) begin
        pass_q <= (mm_nx == '0) && !err_nx;
      end else if (state == FINISH) begin
        pass_q <= pass_q && !error_in;
      end
    end
  end

endmodule

// File: tb/tb_stack_exerciser.sv
// Bench for stack_exerciser: two instances (GAP=0 and GAP=2) share stimulus;
// each is checked every cycle against a schedule-level reference model.
module tb_stack_exerciser;

  logic       clk = 1'b0;
  logic       reset, start, error_in;
  logic [5:0] count;
  logic [7:0] seed;
  logic [1:0] push_v, pop_v, busy_v, done_v, pass_v;
  logic [7:0] dout [2];
  logic [7:0] din [2];
  logic [7:0] mm_v [2];

  always #5 clk = ~clk;

  stack_exerciser #(.DATA_W(8), .DEPTH(32), .GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .start(start), .count(count), .seed(seed),
    .push(push_v[0]), .pop(pop_v[0]), .data_out(dout[0]), .data_in(din[0]),
    .error_in(error_in), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .mismatch_cnt(mm_v[0]));

  stack_exerciser #(.DATA_W(8), .DEPTH(32), .GAP(2)) u_g2 (
    .clk(clk), .reset(reset), .start(start), .count(count), .seed(seed),
    .push(push_v[1]), .pop(pop_v[1]), .data_out(dout[1]), .data_in(din[1]),
    .error_in(error_in), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .mismatch_cnt(mm_v[1]));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  int          start_cyc = 0;
  int          gap_of [2] = '{0, 2};

  // reference model state
  bit          m_run [2];
  int          m_t [2], m_n [2], m_mm [2];
  logic [7:0]  m_sd [2];
  bit          m_err [2], m_pass [2];

  // stack environment and logs
  logic [7:0]  stk [2][$];
  int          pops_done [2];
  bit          corrupt [2];
  logic [7:0]  din_pend [2];
  logic [7:0]  push_log [2][$];
  logic [7:0]  pexp_log [2][$];
  int          pop_cnt [2];
  int          done_rel [2];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      push_log[i].delete();
      pexp_log[i].delete();
      pop_cnt[i]  = 0;
      done_rel[i] = -1;
    end
  endtask

  task automatic do_start(input int c, input int s);
    start     = 1'b1;
    count     = 6'(c);
    seed      = 8'(s);
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_run[0] || m_run[1]) && k < budget) begin
      step();
      k++;
    end
    chk("wait_idle_timeout", int'(m_run[0] || m_run[1]), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    din[0] = din_pend[0];
    din[1] = din_pend[1];
  end

  // Per-cycle compare, logging, stack environment and model advance.
  initial begin
    int         p, total, j, r;
    bit         e_push, e_pop, e_done, e_pass;
    logic [7:0] e_dout, e_exp;
    string      tag;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tag    = $sformatf("g%0d", gap_of[i]);
        p      = 1 + gap_of[i];
        total  = 2 * m_n[i] * p;
        e_push = 1'b0; e_pop = 1'b0; e_done = 1'b0;
        e_dout = '0;   e_exp = '0;
        if (m_run[i]) begin
          if (m_t[i] <= total) begin
            j = (m_t[i] - 1) / p;
            r = (m_t[i] - 1) % p;
            if (r == 0 && j < m_n[i]) begin
              e_push = 1'b1;
              e_dout = 8'(int'(m_sd[i]) + j);
            end else if (r == 0) begin
              e_pop = 1'b1;
              e_exp = 8'(int'(m_sd[i]) + m_n[i] - 1 - (j - m_n[i]));
            end
          end
          e_done = (m_t[i] == total + 1);
        end
        e_pass = (m_run[i] && e_done) ? (m_mm[i] == 0 && !m_err[i]) : m_pass[i];

        chk({tag, "_push"},     int'(push_v[i]), int'(e_push));
        chk({tag, "_pop"},      int'(pop_v[i]),  int'(e_pop));
        chk({tag, "_data_out"}, int'(dout[i]),   int'(e_dout));
        chk({tag, "_busy"},     int'(busy_v[i]), int'(m_run[i]));
        chk({tag, "_done"},     int'(done_v[i]), int'(e_done));
        chk({tag, "_pass"},     int'(pass_v[i]), int'(e_pass));
        chk({tag, "_mismatch"}, int'(mm_v[i]),   m_mm[i]);

        if (push_v[i] === 1'b1) push_log[i].push_back(dout[i]);
        if (pop_v[i] === 1'b1) pop_cnt[i]++;
        if (e_pop) pexp_log[i].push_back(e_exp);
        if (done_v[i] === 1'b1) done_rel[i] = cyc - start_cyc;

        // stack environment reacts to the DUT strobes
        if (reset) begin
          stk[i].delete();
          pops_done[i] = 0;
        end else begin
          if (push_v[i] === 1'b1) stk[i].push_back(dout[i]);
          if (pop_v[i] === 1'b1) begin
            if (stk[i].size() > 0) void'(stk[i].pop_back());
            pops_done[i]++;
          end
          if (busy_v[i] !== 1'b1) pops_done[i] = 0;
        end
        din_pend[i] = (corrupt[i] && pops_done[i] == 1) ? 8'hAA :
                      ((stk[i].size() > 0) ? stk[i][$] : 8'h00);

        // reference model advance
        if (reset) begin
          m_run[i] = 1'b0; m_mm[i] = 0; m_err[i] = 1'b0; m_pass[i] = 1'b0;
        end else if (!m_run[i]) begin
          if (start) begin
            m_run[i]  = 1'b1;
            m_t[i]    = 1;
            m_n[i]    = (int'(count) > 32) ? 32 : int'(count);
            m_sd[i]   = seed;
            m_mm[i]   = 0;
            m_err[i]  = 1'b0;
            m_pass[i] = 1'b0;
          end
        end else begin
          if (e_pop && din[i] != e_exp && m_mm[i] < 255) m_mm[i]++;
          if (error_in) m_err[i] = 1'b1;
          if (e_done) begin
            m_run[i]  = 1'b0;
            m_pass[i] = (m_mm[i] == 0) && !m_err[i];
          end else begin
            m_t[i]++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; error_in = 1'b0; count = '0; seed = '0;
    din[0] = '0; din[1] = '0; din_pend[0] = '0; din_pend[1] = '0;
    corrupt[0] = 1'b0; corrupt[1] = 1'b0;
    clear_logs();
    repeat (3) step();
    reset = 1'b0;
    chk("reset_busy", int'(busy_v), 0);
    chk("reset_pass", int'(pass_v), 0);
    chk("reset_mm0",  int'(mm_v[0]), 0);

    // fill/drain of four, GAP=0 done at 9, GAP=2 at 25
    clear_logs();
    do_start(4, 8'h10);
    wait_idle(200);
    chk("r37_push_n", push_log[0].size(), 4);
    for (int k = 0; k < 4; k++) chk("r37_push_data", int'(push_log[0][k]), 16 + k);
    chk("r37_pop_exp_first", int'(pexp_log[0][0]), 8'h13);
    chk("r37_done_g0", done_rel[0], 9);
    chk("r37_done_g2", done_rel[1], 25);
    chk("r37_pass",    int'(pass_v), 3);
    chk("r37_mm",      int'(mm_v[0]), 0);

    // wrap-around of push data
    clear_logs();
    do_start(3, 8'hFE);
    wait_idle(200);
    chk("r39_push0", int'(push_log[0][0]), 8'hFE);
    chk("r39_push1", int'(push_log[0][1]), 8'hFF);
    chk("r39_push2", int'(push_log[0][2]), 8'h00);
    chk("r39_pexp0", int'(pexp_log[0][0]), 8'h00);
    chk("r39_pexp2", int'(pexp_log[0][2]), 8'hFE);
    chk("r39_pass",  int'(pass_v), 3);

    // count above DEPTH clamps to 32
    clear_logs();
    do_start(40, 8'h5A);
    wait_idle(400);
    chk("r38_push_n_g0", push_log[0].size(), 32);
    chk("r38_pop_n_g0",  pop_cnt[0], 32);
    chk("r38_pop_n_g2",  pop_cnt[1], 32);
    chk("r38_done_g0",   done_rel[0], 65);
    chk("r38_pass",      int'(pass_v), 3);

    // corrupted second pop
    clear_logs();
    corrupt[0] = 1'b1; corrupt[1] = 1'b1;
    do_start(4, 8'h10);
    wait_idle(200);
    corrupt[0] = 1'b0; corrupt[1] = 1'b0;
    chk("r40_mm_g0", int'(mm_v[0]), 1);
    chk("r40_mm_g2", int'(mm_v[1]), 1);
    chk("r40_pass",  int'(pass_v), 0);

    // single error_in pulse mid-run
    clear_logs();
    do_start(4, 8'h20);
    repeat (2) step();
    error_in = 1'b1;
    step();
    error_in = 1'b0;
    wait_idle(200);
    chk("r40_err_pass", int'(pass_v), 0);
    chk("r40_err_mm",   int'(mm_v[1]), 0);

    // empty run
    clear_logs();
    do_start(0, 8'h77);
    wait_idle(50);
    chk("r42_done_g0", done_rel[0], 1);
    chk("r42_done_g2", done_rel[1], 1);
    chk("r42_push_n",  push_log[0].size() + push_log[1].size(), 0);
    chk("r42_pass",    int'(pass_v), 3);

    // start while busy is ignored
    clear_logs();
    do_start(4, 8'h10);
    repeat (2) step();
    start = 1'b1; count = 6'd9; seed = 8'h00;
    step();
    start = 1'b0;
    wait_idle(200);
    chk("r42_busy_done_g0", done_rel[0], 9);
    chk("r42_busy_done_g2", done_rel[1], 25);
    chk("r42_busy_push_n",  push_log[0].size(), 4);

    // reset in the third push gap of the GAP=2 instance
    clear_logs();
    do_start(5, 8'h40);
    while (cyc < start_cyc + 8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r41_busy",   int'(busy_v), 0);
    chk("r41_push",   int'(push_v | pop_v), 0);
    chk("r41_dout",   int'(dout[1]), 0);
    chk("r41_push_n", push_log[1].size(), 3);
    repeat (30) step();
    chk("r41_no_done_g0", done_rel[0], -1);
    chk("r41_no_done_g2", done_rel[1], -1);
    clear_logs();
    do_start(2, 8'h33);
    wait_idle(100);
    chk("r41_rerun_done_g2", done_rel[1], 13);
    chk("r41_rerun_pass",    int'(pass_v), 3);

    // reset dominates a simultaneous start
    reset = 1'b1; start = 1'b1; count = 6'd3;
    step();
    reset = 1'b0; start = 1'b0;
    chk("reset_vs_start", int'(busy_v), 0);

    // randomized traffic
    for (int c = 0; c < 5000; c++) begin
      start    = ($urandom_range(0, 24) == 0);
      count    = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 6)) : 6'($urandom_range(0, 63));
      seed     = 8'($urandom);
      error_in = ($urandom_range(0, 149) == 0);
      reset    = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) == 0) corrupt[0] = ~corrupt[0];
      if ($urandom_range(0, 99) == 0) corrupt[1] = ~corrupt[1];
      step();
    end
    start = 1'b0; error_in = 1'b0; reset = 1'b0;
    wait_idle(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_exerciser.md
STACK_EXERCISER -- requirements
Module: stack_exerciser

Interface
REQ-001 Parameter: DATA_W, 8, data width of the stack port.
REQ-002 Parameter: DEPTH, 32, stack capacity in entries.
REQ-003 Parameter: GAP, 2, idle cycles inserted after every push or pop pulse (0 allowed).
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to run a fill/drain sequence.
REQ-007 count  input  6  entries to push then pop (0..63).
REQ-008 seed  input  DATA_W  first push value.
REQ-009 push  output  1  one-cycle push strobe to stack.
REQ-010 pop  output  1  one-cycle pop strobe to stack.
REQ-011 data_out  output  DATA_W  push data, valid when push=1.
REQ-012 data_in  input  DATA_W  stack top-of-stack value, sampled when pop=1.
REQ-013 error_in  input  1  stack overflow/underflow flag.
REQ-014 busy  output  1  high from cycle after accepted start until done.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 pass  output  1  result of last run, held until next accepted start.
REQ-017 mismatch_cnt  output  8  pop-data mismatches in last run, saturating at 255.

Function
REQ-018 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-019 On acceptance, count and seed SHALL be latched; effective N = min(count, DEPTH).
REQ-020 FSM states: IDLE, PUSH, PUSH_GAP, POP, POP_GAP, FINISH.
REQ-021 IDLE->PUSH on accepted start with N>0; IDLE->FINISH on accepted start with N=0.
REQ-022 PUSH: push=1 for exactly one cycle with data_out = (seed + i) mod 2^DATA_W, i = 0..N-1; then PUSH_GAP for GAP cycles (skipped if GAP=0).
REQ-023 After the N-th push and its gap, FSM SHALL enter POP; else return to PUSH.
REQ-024 POP: pop=1 for exactly one cycle; data_in compared in that same cycle against expected (seed + N-1-k) mod 2^DATA_W, k = 0..N-1; then POP_GAP for GAP cycles.
REQ-025 After the N-th pop and its gap, FSM SHALL enter FINISH; FINISH asserts done for one cycle and returns to IDLE.
REQ-026 push and pop SHALL never be high in the same cycle.
REQ-027 Each mismatch SHALL increment mismatch_cnt, saturating at 255.
REQ-028 error_in high in any busy cycle SHALL force fail for the run; sequence continues to completion.
REQ-029 pass SHALL be set in the done cycle to 1 iff mismatch_cnt=0 and no error_in seen; cleared on accepted start.
REQ-030 Timing: start accepted at cycle 0 -> first push at cycle 1; done at cycle 2N(1+GAP)+1; N=0 -> done at cycle 1 with pass=1.
REQ-031 data_out SHALL hold 0 when push=0.

Reset
REQ-032 reset SHALL force state IDLE, push=0, pop=0, data_out=0, busy=0, done=0, pass=0, mismatch_cnt=0 on the next edge.
REQ-033 Reset mid-run SHALL abort immediately without emitting done; no further push/pop pulses.
REQ-034 reset SHALL dominate start in the same cycle.

Structure
REQ-035 A shared package stack_pkg SHALL hold DATA_W, DEPTH defaults, and the exerciser state enumeration.
REQ-036 A sub-module stack_gap_timer (load GAP, count down, expire pulse) SHALL implement the gap delay.

Verification
REQ-037 count=4, seed=0x10, GAP=0, ideal stack -> pushes 0x10,0x11,0x12,0x13, pops expect 0x13..0x10, done at cycle 9, pass=1, mismatch_cnt=0.
REQ-038 count=40, DEPTH=32 -> exactly 32 pushes and 32 pops, no error_in, pass=1.
REQ-039 count=3, seed=0xFE -> push data 0xFE,0xFF,0x00 (wrap), pops expect 0x00,0xFF,0xFE, pass=1.
REQ-040 Stack model corrupts second pop to 0xAA, count=4 -> mismatch_cnt=1, pass=0; error_in pulsed once in another run -> pass=0.
REQ-041 reset asserted during third push gap with GAP=2 -> all outputs 0 next cycle, no done; new start then runs normally.
REQ-042 count=0 -> done at cycle 1, pass=1, no push/pop; start re-pulsed while busy -> ignored, cycle count unchanged.
